// File: rtl/rename_stage_pkg.sv
// rtl/rename_stage_pkg.sv - shared constants and payload layout for the rename stage
package rename_stage_pkg;

  localparam int NUM_ARCH = 32;
  localparam int TAG_W    = 6;
  localparam int FL_DEPTH = 32;
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = 7;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Payload bundle {opcode, funct3, funct7, imm, lwSw, aluOp, controlSignals}
  localparam int PL_CTRL_LSB   = 0;
  localparam int PL_ALUOP_LSB  = 7;
  localparam int PL_LWSW_LSB   = 9;
  localparam int PL_IMM_LSB    = 10;
  localparam int PL_FUNCT7_LSB = 42;
  localparam int PL_FUNCT3_LSB = 49;
  localparam int PL_OPCODE_LSB = 52;

  function automatic logic [6:0] payload_opcode(input logic [58:0] p);
    return p[PL_OPCODE_LSB +: 7];
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular free list of physical tags with sticky overflow flag
module rename_free_list
  import rename_stage_pkg::*;
#(
  parameter int NUM_PHYS = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pop,
  input  logic             pushValid,
  input  logic [TAG_W-1:0] pushTag,
  output logic [TAG_W-1:0] headTag,
  output logic [CNT_W-1:0] count,
  output logic             overflowErr
);

  logic [TAG_W-1:0] mem [FL_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push_req;
  logic             full;
  logic             push_ok;

  assign headTag  = mem[head];
  assign push_req = pushValid && (pushTag != '0);
  assign full     = (count == CNT_W'(FL_DEPTH));
  // A same-cycle pop makes room, so a push into a full list is still legal then
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= TAG_W'(NUM_PHYS - FL_DEPTH + i);
      head        <= '0;
      tail        <= '0;
      count       <= CNT_W'(FL_DEPTH);
      overflowErr <= 1'b0;
    end else begin
      if (pop) head <= head + 1'b1;
      if (push_ok) begin
        mem[tail] <= pushTag;
        tail      <= tail + 1'b1;
      end
      if (push_req && !push_ok) overflowErr <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - single-issue register rename: RAT lookup, tag allocation, output register
module rename_stage
  import rename_stage_pkg::*;
#(
  parameter int NUM_PHYS  = 64,
  parameter int PAYLOAD_W = 59
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [4:0]           srcReg1,
  input  logic [4:0]           srcReg2,
  input  logic [4:0]           destReg,
  input  logic                 regWrite,
  input  logic [PAYLOAD_W-1:0] payloadIn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [TAG_W-1:0]     physSrc1,
  output logic [TAG_W-1:0]     physSrc2,
  output logic [TAG_W-1:0]     physDest,
  output logic [TAG_W-1:0]     oldPhysDest,
  output logic                 allocValid,
  output logic [PAYLOAD_W-1:0] payloadOut,
  input  logic                 retireValid,
  input  logic [TAG_W-1:0]     retireTag,
  output logic [CNT_W-1:0]     freeCount,
  output logic                 overflowErr
);

  logic [TAG_W-1:0] rat [NUM_ARCH];
  logic             need_alloc;
  logic             accept;
  logic             pop;
  logic [TAG_W-1:0] head_tag;

  assign need_alloc = regWrite && (destReg != 5'd0);
  // Uses the registered count: a same-cycle retire cannot unblock an empty list
  assign inReady    = (!outValid || outReady) && (!need_alloc || (freeCount != '0));
  assign accept     = inValid && inReady;
  assign pop        = accept && need_alloc;

  rename_free_list #(.NUM_PHYS(NUM_PHYS)) u_free_list (
    .clk         (clk),
    .rstn        (rstn),
    .pop         (pop),
    .pushValid   (retireValid),
    .pushTag     (retireTag),
    .headTag     (head_tag),
    .count       (freeCount),
    .overflowErr (overflowErr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ARCH; i++) rat[i] <= TAG_W'(i);
      outValid    <= 1'b0;
      physSrc1    <= '0;
      physSrc2    <= '0;
      physDest    <= '0;
      oldPhysDest <= '0;
      allocValid  <= 1'b0;
      payloadOut  <= '0;
    end else if (accept) begin
      outValid   <= 1'b1;
      physSrc1   <= (srcReg1 == 5'd0) ? '0 : rat[srcReg1];
      physSrc2   <= (srcReg2 == 5'd0) ? '0 : rat[srcReg2];
      payloadOut <= payloadIn;
      if (need_alloc) begin
        physDest     <= head_tag;
        oldPhysDest  <= rat[destReg];
        allocValid   <= 1'b1;
        rat[destReg] <= head_tag;
      end else begin
        physDest    <= '0;
        oldPhysDest <= '0;
        allocValid  <= 1'b0;
      end
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - directed and randomized checks of rename_stage against a queue-based model
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  srcReg1 = '0, srcReg2 = '0, destReg = '0;
  logic        regWrite = 1'b0;
  logic [58:0] payloadIn = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [5:0]  physSrc1, physSrc2, physDest, oldPhysDest;
  logic        allocValid;
  logic [58:0] payloadOut;
  logic        retireValid = 1'b0;
  logic [5:0]  retireTag = '0;
  logic [6:0]  freeCount;
  logic        overflowErr;

  rename_stage #(.NUM_PHYS(64), .PAYLOAD_W(59)) dut (
    .clk(clk), .rstn(rstn), .inValid(inValid), .inReady(inReady),
    .srcReg1(srcReg1), .srcReg2(srcReg2), .destReg(destReg), .regWrite(regWrite),
    .payloadIn(payloadIn), .outValid(outValid), .outReady(outReady),
    .physSrc1(physSrc1), .physSrc2(physSrc2), .physDest(physDest),
    .oldPhysDest(oldPhysDest), .allocValid(allocValid), .payloadOut(payloadOut),
    .retireValid(retireValid), .retireTag(retireTag), .freeCount(freeCount),
    .overflowErr(overflowErr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          rat_m [32];
  int          fl_m [$];
  int          pool [$];
  bit          mv, m_av, movf;
  int          m_s1, m_s2, m_pd, m_opd;
  logic [58:0] m_pl;
  logic        last_rdy;

  logic [6:0] opcs [5];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat_m[i] = i;
    fl_m.delete();
    for (int t = 32; t < 64; t++) fl_m.push_back(t);
    pool.delete();
    mv = 0; m_av = 0; movf = 0;
    m_s1 = 0; m_s2 = 0; m_pd = 0; m_opd = 0; m_pl = '0;
  endtask

  function automatic bit m_ready();
    bit need = regWrite && (destReg != 0);
    return (!mv || outReady) && (!need || fl_m.size() != 0);
  endfunction

  task automatic model_edge();
    bit need = regWrite && (destReg != 0);
    bit acc  = inValid && m_ready();
    bit push = retireValid && (retireTag != 0);
    bit full_before = (fl_m.size() == 32);
    bit popq = acc && need;
    if (acc) begin
      mv   = 1;
      m_s1 = (srcReg1 == 0) ? 0 : rat_m[srcReg1];
      m_s2 = (srcReg2 == 0) ? 0 : rat_m[srcReg2];
      m_pl = payloadIn;
      if (need) begin
        m_pd  = fl_m.pop_front();
        m_opd = rat_m[destReg];
        m_av  = 1;
        rat_m[destReg] = m_pd;
        pool.push_back(m_opd);
      end else begin
        m_pd = 0; m_opd = 0; m_av = 0;
      end
    end else if (mv && outReady) begin
      mv = 0;
    end
    if (push) begin
      if (!full_before || popq) fl_m.push_back(int'(retireTag));
      else movf = 1;
    end
  endtask

  task automatic check_outs();
    chk("outValid", outValid, mv);
    chk("freeCount", freeCount, fl_m.size());
    chk("overflowErr", overflowErr, movf);
    if (mv) begin
      chk("physSrc1", physSrc1, m_s1);
      chk("physSrc2", physSrc2, m_s2);
      chk("physDest", physDest, m_pd);
      chk("oldPhysDest", oldPhysDest, m_opd);
      chk("allocValid", allocValid, m_av);
      chk("payloadOut", payloadOut, m_pl);
    end
  endtask

  // One clock cycle: drive at negedge, check inReady, advance model, check registered outputs
  task automatic cyc(input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic rw, input logic ordy,
                     input logic rv, input logic [5:0] rt);
    logic [58:0] p;
    p = {$urandom, $urandom};
    p[PL_OPCODE_LSB +: 7] = opcs[$urandom_range(0, 4)];
    inValid = iv; srcReg1 = s1; srcReg2 = s2; destReg = d; regWrite = rw;
    payloadIn = p; outReady = ordy; retireValid = rv; retireTag = rt;
    #1;
    last_rdy = inReady;
    chk("inReady", inReady, m_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    rstn = 1'b0; inValid = 1'b0; retireValid = 1'b0; outReady = 1'b1;
    #1;
    chk("rst_outValid", outValid, 0);
    chk("rst_freeCount", freeCount, 32);
    chk("rst_allocValid", allocValid, 0);
    chk("rst_overflow", overflowErr, 0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    logic iv, rw, ordy, rv;
    logic [5:0] rt;
    opcs[0] = OPC_RTYPE; opcs[1] = OPC_ITYPE; opcs[2] = OPC_LOAD;
    opcs[3] = OPC_STORE; opcs[4] = OPC_BRANCH;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outValid", outValid, 0);
    chk("reset_freeCount", freeCount, 32);
    chk("reset_physDest", physDest, 0);
    chk("reset_payload", payloadOut, 0);
    chk("reset_inReady", inReady, 1);
    rstn = 1'b1;

    // add x3,x1,x2 then sub x4,x3,x3
    cyc(1, 1, 2, 3, 1, 1, 0, 0);
    chk("add_src1", physSrc1, 1);
    chk("add_src2", physSrc2, 2);
    chk("add_dest", physDest, 32);
    chk("add_old", oldPhysDest, 3);
    chk("add_av", allocValid, 1);
    chk("add_cnt", freeCount, 31);
    cyc(1, 3, 3, 4, 1, 1, 0, 0);
    chk("sub_src1", physSrc1, 32);
    chk("sub_src2", physSrc2, 32);
    chk("sub_dest", physDest, 33);
    chk("sub_old", oldPhysDest, 4);

    // x0 destination, then a store: no allocation, no stall
    cyc(1, 4, 0, 0, 1, 1, 0, 0);
    chk("x0_rdy", last_rdy, 1);
    chk("x0_dest", physDest, 0);
    chk("x0_av", allocValid, 0);
    chk("x0_src1", physSrc1, 33);
    cyc(1, 3, 4, 5, 0, 1, 0, 0);
    chk("st_rdy", last_rdy, 1);
    chk("st_av", allocValid, 0);
    chk("st_cnt", freeCount, 30);

    // Drain the free list completely
    do_reset();
    for (int k = 0; k < 32; k++) begin
      cyc(1, 5'($urandom), 5'($urandom), 5'((k % 31) + 1), 1, 1, 0, 0);
      chk("drain_dest", physDest, 32 + k);
    end
    chk("drain_cnt", freeCount, 0);
    cyc(1, 1, 2, 1, 1, 1, 1, 5);
    chk("empty_rdy", last_rdy, 0);
    chk("empty_cnt", freeCount, 1);
    cyc(1, 1, 2, 1, 1, 1, 0, 0);
    chk("refill_rdy", last_rdy, 1);
    chk("refill_dest", physDest, 5);
    chk("refill_cnt", freeCount, 0);

    // Mid-operation reset restores identity RAT and full free list
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 5'(k + 1), 1, 1, 0, 0);
    chk("pre_rst_cnt", freeCount, 22);
    do_reset();
    cyc(1, 3, 9, 0, 0, 1, 0, 0);
    chk("rat_id1", physSrc1, 3);
    chk("rat_id2", physSrc2, 9);

    // Backpressure: outputs hold, no RAT update, release accepts same cycle
    cyc(1, 1, 2, 7, 1, 1, 0, 0);
    chk("bp_first", physDest, 32);
    repeat (3) begin
      cyc(1, 7, 0, 8, 1, 0, 0, 0);
      chk("bp_rdy", last_rdy, 0);
      chk("bp_hold", physDest, 32);
      chk("bp_valid", outValid, 1);
      chk("bp_cnt", freeCount, 31);
    end
    cyc(1, 7, 0, 8, 1, 1, 0, 0);
    chk("bp_rel_rdy", last_rdy, 1);
    chk("bp_rel_src1", physSrc1, 32);
    chk("bp_rel_dest", physDest, 33);
    chk("bp_rel_old", oldPhysDest, 8);

    // Overflow on push into full list; tag 0 ignored
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 1, 40);
    chk("ovf_set", overflowErr, 1);
    chk("ovf_cnt", freeCount, 32);
    cyc(1, 0, 0, 6, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    chk("tag0_cnt", freeCount, 31);
    chk("ovf_sticky", overflowErr, 1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      rw   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      rv   = 1'b0;
      rt   = '0;
      if (pool.size() != 0 && $urandom_range(0, 2) == 0) begin
        rv = 1'b1;
        rt = 6'(pool.pop_front());
      end else if ($urandom_range(0, 15) == 0) begin
        rv = 1'b1;
      end
      cyc(iv, 5'($urandom), 5'($urandom), 5'($urandom), rw, ordy, rv, rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
